// File: rtl/unreg_pkg.sv
// Shared types and constants for the word sequencer and its update network.
package unreg_pkg;

  localparam int WORD_WIDTH = 16;

  // Command opcodes as they arrive on cmd_op.
  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ROT  = 2'd2,
    OP_INV  = 2'd3
  } op_e;

  // Per-cycle update applied to the word register.
  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_CLR  = 3'd1,
    MODE_LOAD = 3'd2,
    MODE_ROT1 = 3'd3,
    MODE_INV  = 3'd4
  } mode_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

endpackage

// File: rtl/unreg_word_update.sv
// Combinational next-word function: selects what the word register takes next.
module unreg_word_update
  import unreg_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [WIDTH-1:0] word,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_word
);

  // Pick the next word from the current word according to the update mode.
  always_comb begin
    // NOTE: default first so every path assigns next_word and no latch is inferred.
    next_word = word;
    case (mode)
      MODE_CLR:  next_word = '0;
      MODE_LOAD: next_word = load_data;
      MODE_ROT1: next_word = {word[WIDTH-2:0], word[WIDTH-1]};
      MODE_INV:  next_word = ~word;
      default:   next_word = word;
    endcase
  end

endmodule

// File: rtl/unreg_word_sequencer.sv
// Command sequencer: accepts multi-cycle word commands, drives the update
// network one mode per clock and returns the resulting word downstream.
module unreg_word_sequencer
  import unreg_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           r_state;
  state_e           w_next_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_load_data;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_next_remaining;
  logic [WIDTH-1:0] w_next_word;
  mode_e            w_mode;
  logic             w_accept;

  assign w_accept  = cmd_valid && cmd_ready;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_RESULT);
  assign out_data  = r_word;

  unreg_word_update #(
    .WIDTH(WIDTH)
  ) u_word_update (
    .word      (r_word),
    .mode      (w_mode),
    .load_data (r_load_data),
    .next_word (w_next_word)
  );

  // Next state, update mode and rotation bookkeeping.
  always_comb begin
    w_next_state     = r_state;
    w_mode           = MODE_HOLD;
    w_next_remaining = r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_remaining = cmd_count;
          if (op_e'(cmd_op) == OP_ROT && cmd_count == '0) begin
            w_next_state = ST_RESULT;
          end else begin
            w_next_state = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        w_next_state = ST_RESULT;
        case (r_op)
          OP_CLR:  w_mode = MODE_CLR;
          OP_LOAD: w_mode = MODE_LOAD;
          OP_INV:  w_mode = MODE_INV;
          default: begin
            w_mode = MODE_ROT1;
            if (r_remaining > CNT_W'(1)) begin
              w_next_remaining = r_remaining - CNT_W'(1);
              w_next_state     = ST_ROTATE;
            end else begin
              w_next_remaining = '0;
            end
          end
        endcase
      end
      ST_ROTATE: begin
        w_mode = MODE_ROT1;
        if (r_remaining > CNT_W'(1)) begin
          w_next_remaining = r_remaining - CNT_W'(1);
        end else begin
          w_next_remaining = '0;
          w_next_state     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, word, counter and captured command registers.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_CLR;
      r_word      <= '0;
      r_load_data <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_next_state;
      r_word      <= w_next_word;
      r_remaining <= w_next_remaining;
      if (w_accept) begin
        r_op        <= op_e'(cmd_op);
        r_load_data <= cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_unreg_word_sequencer.sv
// Self-checking bench for unreg_word_sequencer: directed scenarios plus
// randomized commands compared against a behavioural word/latency model.
module tb_unreg_word_sequencer;
  import unreg_pkg::*;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [3:0]  cmd_count;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_word;

  unreg_word_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Rotate-left by n expressed with shifts on a 16-bit word.
  function automatic logic [15:0] rotl(input logic [15:0] w, input int n);
    int k;
    k = n % 16;
    if (k == 0) return w;
    return (w << k) | (w >> (16 - k));
  endfunction

  // Issue one command, check latency and result, optionally stall downstream.
  task automatic run_cmd(input op_e op, input logic [15:0] data, input logic [3:0] count,
                         input int stall);
    int edges;
    int exp_edges;
    @(negedge clock);
    check("cmd_ready_idle", cmd_ready, 1);
    out_ready = (stall == 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 16'($urandom);
    cmd_count = 4'($urandom);
    case (op)
      OP_CLR:  exp_word = 16'h0000;
      OP_LOAD: exp_word = data;
      OP_INV:  exp_word = ~exp_word;
      default: exp_word = rotl(exp_word, int'(count));
    endcase
    exp_edges = (op == OP_ROT) ? int'(count) : 1;
    check("busy_after_accept", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(negedge clock);
      edges++;
    end
    check("latency", edges, exp_edges);
    check("result", out_data, exp_word);
    if (stall > 0) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_INV;
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, exp_word);
        check("stall_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 0);
    check("done_ready", cmd_ready, 1);
    check("done_word", out_data, exp_word);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen_valid;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 16'h0;
    cmd_count = 4'd0;
    out_ready = 1'b0;
    exp_word  = 16'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 16'h0);

    // Directed scenarios.
    run_cmd(OP_LOAD, 16'h1234, 4'd0, 0);
    run_cmd(OP_LOAD, 16'h8001, 4'd0, 0);
    run_cmd(OP_ROT,  16'hFFFF, 4'd3, 0);
    check("rot3_value", out_data, 16'h000C);
    run_cmd(OP_LOAD, 16'h8001, 4'd0, 0);
    run_cmd(OP_ROT,  16'h0000, 4'd0, 0);
    check("rot0_value", out_data, 16'h8001);
    run_cmd(OP_LOAD, 16'h0001, 4'd0, 0);
    run_cmd(OP_ROT,  16'h0000, 4'd15, 0);
    check("rot15_value", out_data, 16'h8000);
    run_cmd(OP_LOAD, 16'h00FF, 4'd0, 0);
    run_cmd(OP_INV,  16'h1111, 4'd0, 0);
    check("inv_value", out_data, 16'hFF00);
    run_cmd(OP_CLR,  16'h2222, 4'd0, 0);
    check("clr_value", out_data, 16'h0000);
    run_cmd(OP_LOAD, 16'h5A5A, 4'd0, 0);
    run_cmd(OP_INV,  16'h0000, 4'd0, 5);
    check("bp_value", out_data, 16'hA5A5);

    // Reset during a long rotate aborts it with no stale result.
    run_cmd(OP_LOAD, 16'h0F0F, 4'd0, 0);
    @(negedge clock);
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_ROT;
    cmd_count = 4'd10;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_word = 16'h0;
    check("abort_word", out_data, 16'h0);
    check("abort_valid", out_valid, 0);
    check("abort_ready", cmd_ready, 1);
    seen_valid = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen_valid++;
    end
    check("no_stale_result", seen_valid, 0);
    out_ready = 1'b0;

    // Randomized commands against the model.
    for (int n = 0; n < 40; n++) begin
      run_cmd(op_e'($urandom_range(0, 3)), 16'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unreg_word_sequencer.md
Name: unreg_word_sequencer

Overview:
- Sequential stage wrapped around the combinational 16-bit word-update network.
- Owns the state word register and issues one update mode per clock: clear, load, rotate-by-one or complement.
- Takes multi-cycle commands over a valid/ready handshake from upstream.
- Returns the resulting word over a valid/ready handshake to downstream.

Parameters:
- WIDTH, 16, width of the state word and of the data buses.
- CNT_W, 4, width of the rotate count; must equal $clog2(WIDTH).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  command: 0=CLR, 1=LOAD, 2=ROT, 3=INV.
- cmd_data  in  WIDTH  parallel word for LOAD; ignored otherwise.
- cmd_count  in  CNT_W  number of single-bit rotations for ROT; ignored otherwise.
- out_valid  out  1  result word presented.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  current state word; always driven, meaningful when out_valid=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - state word = 0; FSM = IDLE.
  - cmd_ready = 1, out_valid = 0, busy = 0, out_data = 0.
  - Reset mid-command aborts the command and discards any pending result.
- Update modes, applied to the word register for one cycle:
  - CLR: word <= 0.
  - LOAD: word <= cmd_data, captured at the accept edge.
  - ROT1: word <= {word[WIDTH-2:0], word[WIDTH-1]}, i.e. rotate left by one.
  - INV: word <= ~word.
  - HOLD: word unchanged.
- FSM states: IDLE, EXEC, ROTATE, RESULT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_op and cmd_count.
  - ROT with count=0: go straight to RESULT with the word unchanged; zero-cycle execute.
  - All other commands go to EXEC.
- EXEC:
  - Applies CLR, LOAD or INV in one cycle, then goes to RESULT.
  - ROT with count>0: first ROT1 applied here, remaining = count-1; go to RESULT if remaining=0, else to ROTATE.
- ROTATE:
  - Applies ROT1 every cycle and decrements remaining.
  - Goes to RESULT on the cycle remaining reaches 0.
  - Total ROT execution cycles = count.
- RESULT:
  - out_valid = 1; out_data stable; word held.
  - On out_ready, go to IDLE the next cycle.
  - No same-cycle re-accept: cmd_ready is 0 outside IDLE, giving minimum one idle cycle between commands.
- Latency from the accept edge to out_valid:
  - CLR, LOAD, INV: 2 cycles.
  - ROT n: n+1 cycles for n>0; 1 cycle for n=0.
- Handshake rules:
  - Upstream may hold cmd_valid while cmd_ready=0; nothing is latched.
  - out_valid, once high, stays high with constant out_data until out_ready is sampled high (no drop, no change).
  - out_ready high while out_valid=0 is ignored.
- Boundaries:
  - ROT count=15 yields rotate-right-by-one.
  - cmd_op and cmd_data changes after accept have no effect.
  - Word persists across commands; INV/ROT operate on the previous result.
- Arithmetic: remaining counter is CNT_W bits, unsigned; it is never decremented below 0.

Decomposition:
- Shared package unreg_pkg:
  - op enum (CLR, LOAD, ROT, INV).
  - mode enum (HOLD, CLR, LOAD, ROT1, INV).
  - FSM state enum.
  - WIDTH default constant.
- One sub-module, unreg_word_update: purely combinational next-word function (word, mode, load_data -> next_word).
- The sequencer instantiates unreg_word_update and owns the word register, FSM and counter.

Test Plan:
- Reset, then LOAD 0x1234 with out_ready=1 -> out_valid on the 2nd cycle after accept, out_data=0x1234, busy low one cycle later.
- From 0x8001, ROT count=3 -> out_valid 4 cycles after accept, out_data=0x000C.
- From 0x8001, ROT count=0 -> out_valid next cycle, out_data=0x8001; ROT count=15 from 0x0001 -> 0x8000.
- LOAD 0x00FF, then INV, then CLR, out_ready=1 -> results 0x00FF, 0xFF00, 0x0000 in order; cmd_ready=0 whenever busy=1.
- Backpressure: INV with out_ready=0 for 5 cycles -> out_valid stays 1, out_data constant, cmd_ready stays 0, a new cmd_valid is not accepted; release -> IDLE next cycle.
- Assert reset during ROTATE of ROT count=10 -> next cycle word=0, out_valid=0, cmd_ready=1, no stale result emitted.
